ps2_host_tx: RTL and testbench

// Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable,
// 0xFF reset) to the keyboard over the same open-drain PS2_CLK/PS2_DATA pair used by the keyboard

---
 rtl/ps2_host_tx_if.sv | 25 ++
 rtl/ps2_host_tx.sv | 225 ++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_host_tx_if.sv
// Bundle of the command handshake, the PS/2 pin levels and the transfer status.
// The slave modport is the transmitter; the master modport is whoever issues
// commands and models the pins.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_low;
  logic       ps2_data_low;
  logic       busy;
  logic       done;
  logic [1:0] status;

  modport slave (
    input  tx_data, tx_valid, ps2_clk_in, ps2_data_in,
    output tx_ready, ps2_clk_low, ps2_data_low, busy, done, status
  );

  modport master (
    output tx_data, tx_valid, ps2_clk_in, ps2_data_in,
    input  tx_ready, ps2_clk_low, ps2_data_low, busy, done, status
  );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter. Inhibits the bus, issues a
// request-to-send, shifts out d0..d7, odd parity and stop on device clock
// falls, samples the device acknowledge and reports ack / nack / timeout.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int FILTER_LEN     = 4
) (
  input logic          clk,
  input logic          rst,
  ps2_host_tx_if.slave bus
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FW = $clog2(FILTER_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_START,
    S_SEND,
    S_ACK,
    S_RELEASE
  } state_t;

  // Pin synchronisers (idle level of an open-drain bus is high)
  logic clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;

  // Clock glitch filter
  logic          clk_filt_q, clk_filt_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          fall;

  // Transfer state
  state_t        state_q, state_d;
  logic [9:0]    shift_q, shift_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [IW-1:0] inh_cnt_q, inh_cnt_d;
  logic [TW-1:0] wdog_q, wdog_d;
  logic          nack_q, nack_d;

  // Registered outputs
  logic       clk_low_q, clk_low_d;
  logic       data_low_q, data_low_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [1:0] status_q, status_d;
  logic       tx_ready_q, tx_ready_d;

  logic timeout;

  // Filtered clock only flips after FILTER_LEN consecutive differing samples;
  // a fall is that flip from 1 to 0.
  always_comb begin
    clk_filt_d = clk_filt_q;
    filt_cnt_d = '0;
    fall       = 1'b0;
    if (clk_s2_q != clk_filt_q) begin
      if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
        clk_filt_d = clk_s2_q;
        fall       = clk_filt_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  assign timeout = (wdog_q == TW'(TIMEOUT_CYCLES - 1));

  // Next-state and next-output logic of the transfer sequencer
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    inh_cnt_d  = inh_cnt_q;
    wdog_d     = wdog_q;
    nack_d     = nack_q;
    clk_low_d  = clk_low_q;
    data_low_d = data_low_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    status_d   = status_q;
    tx_ready_d = tx_ready_q;

    case (state_q)
      S_IDLE: begin
        if (bus.tx_valid && tx_ready_q) begin
          shift_d    = {1'b1, ~^bus.tx_data, bus.tx_data};
          bit_cnt_d  = '0;
          inh_cnt_d  = '0;
          wdog_d     = '0;
          clk_low_d  = 1'b1;
          data_low_d = 1'b0;
          busy_d     = 1'b1;
          tx_ready_d = 1'b0;
          state_d    = S_INHIBIT;
        end
      end

      S_INHIBIT: begin
        inh_cnt_d = inh_cnt_q + 1'b1;
        // Start bit goes out in the final inhibit cycle
        if (inh_cnt_q == IW'(INHIBIT_CYCLES - 2)) begin
          data_low_d = 1'b1;
        end
        if (inh_cnt_q == IW'(INHIBIT_CYCLES - 1)) begin
          clk_low_d = 1'b0;
          wdog_d    = '0;
          state_d   = S_START;
        end
      end

      default: begin
        if (timeout) begin
          // Timeout has priority over a coincident fall
          clk_low_d  = 1'b0;
          data_low_d = 1'b0;
          done_d     = 1'b1;
          status_d   = 2'b10;
          busy_d     = 1'b0;
          tx_ready_d = 1'b1;
          state_d    = S_IDLE;
        end else begin
          wdog_d = fall ? '0 : wdog_q + 1'b1;
          case (state_q)
            S_START: begin
              if (fall) begin
                data_low_d = ~shift_q[0];
                shift_d    = {1'b1, shift_q[9:1]};
                bit_cnt_d  = 4'd1;
                state_d    = S_SEND;
              end
            end
            S_SEND: begin
              if (fall) begin
                data_low_d = ~shift_q[0];
                shift_d    = {1'b1, shift_q[9:1]};
                bit_cnt_d  = bit_cnt_q + 1'b1;
                // Tenth fall has just put the stop bit on the line
                if (bit_cnt_q == 4'd9) begin
                  state_d = S_ACK;
                end
              end
            end
            S_ACK: begin
              data_low_d = 1'b0;
              if (fall) begin
                nack_d  = dat_s2_q;
                state_d = S_RELEASE;
              end
            end
            S_RELEASE: begin
              if (clk_filt_q && dat_s2_q) begin
                done_d     = 1'b1;
                status_d   = {1'b0, nack_q};
                busy_d     = 1'b0;
                tx_ready_d = 1'b1;
                state_d    = S_IDLE;
              end
            end
            default: begin
              clk_low_d  = 1'b0;
              data_low_d = 1'b0;
              busy_d     = 1'b0;
              tx_ready_d = 1'b1;
              state_d    = S_IDLE;
            end
          endcase
        end
      end
    endcase
  end

  // State, synchronisers, filter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      clk_filt_q <= 1'b1;
      filt_cnt_q <= '0;
      state_q    <= S_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      inh_cnt_q  <= '0;
      wdog_q     <= '0;
      nack_q     <= 1'b0;
      clk_low_q  <= 1'b0;
      data_low_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      status_q   <= 2'b00;
      tx_ready_q <= 1'b1;
    end else begin
      clk_s1_q   <= bus.ps2_clk_in;
      clk_s2_q   <= clk_s1_q;
      dat_s1_q   <= bus.ps2_data_in;
      dat_s2_q   <= dat_s1_q;
      clk_filt_q <= clk_filt_d;
      filt_cnt_q <= filt_cnt_d;
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      inh_cnt_q  <= inh_cnt_d;
      wdog_q     <= wdog_d;
      nack_q     <= nack_d;
      clk_low_q  <= clk_low_d;
      data_low_q <= data_low_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      status_q   <= status_d;
      tx_ready_q <= tx_ready_d;
    end
  end

  assign bus.ps2_clk_low  = clk_low_q;
  assign bus.ps2_data_low = data_low_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.status       = status_q;
  assign bus.tx_ready     = tx_ready_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain pin model and a simple
// keyboard model that clocks the frame in and optionally acknowledges it.
module tb_ps2_host_tx;
  localparam int INH  = 300;
  localparam int TMO  = 3000;
  localparam int HALF = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ps2_host_tx_if bus();

  logic dev_clk_low  = 1'b0;
  logic dev_data_low = 1'b0;
  assign bus.ps2_clk_in  = ~(bus.ps2_clk_low | dev_clk_low);
  assign bus.ps2_data_in = ~(bus.ps2_data_low | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO),
    .FILTER_LEN(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  // Every cycle with done high adds one, so a wide pulse shows up as extra counts
  always @(posedge clk) if (bus.done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_tx(input logic [7:0] b);
    @(negedge clk);
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  // Measures the inhibit phase; returns at the first cycle of START
  task automatic run_inhibit();
    int n = 0;
    int didx = -1;
    while (bus.ps2_clk_low === 1'b1 && n < INH + 50) begin
      if (didx < 0 && bus.ps2_data_low === 1'b1) didx = n;
      n++;
      @(negedge clk);
    end
    check("inhibit_len", n, INH);
    check("start_bit_cycle", didx, INH - 1);
    check("rts_data_low", bus.ps2_data_low, 1'b1);
    check("rts_busy", bus.busy, 1'b1);
    check("rts_tx_ready", bus.tx_ready, 1'b0);
  endtask

  // Keyboard model: 11 clocks, samples data on each rise. poke_rise injects a
  // stray request after that rise; rst_fall resets the host during that low phase.
  task automatic device(input bit do_ack, input int poke_rise, input int rst_fall,
                        output logic [9:0] frame, output bit aborted);
    frame = '0;
    aborted = 1'b0;
    repeat (20) @(negedge clk);
    for (int i = 1; i <= 11; i++) begin
      dev_clk_low = 1'b1;
      if (i == rst_fall) begin
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_clk_rel", bus.ps2_clk_low, 1'b0);
        check("rst_data_rel", bus.ps2_data_low, 1'b0);
        check("rst_tx_ready", bus.tx_ready, 1'b1);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        rst = 1'b0;
        dev_clk_low = 1'b0;
        aborted = 1'b1;
        return;
      end
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      if (i <= 10) frame[i-1] = bus.ps2_data_in;
      for (int c = 0; c < HALF; c++) begin
        @(negedge clk);
        if (i == poke_rise && c == 2) begin
          bus.tx_data  = 8'h00;
          bus.tx_valid = 1'b1;
        end
        if (i == poke_rise && c == 5) begin
          check("poke_busy", bus.busy, 1'b1);
          check("poke_tx_ready", bus.tx_ready, 1'b0);
        end
        if (i == poke_rise && c == 6) bus.tx_valid = 1'b0;
        if (i == 10 && do_ack && c == 10) dev_data_low = 1'b1;
        if (i == 11 && c == 5) dev_data_low = 1'b0;
      end
    end
  endtask

  task automatic check_idle(input string tag, input logic [1:0] st);
    check({tag, "_status"}, bus.status, st);
    check({tag, "_busy"}, bus.busy, 1'b0);
    check({tag, "_tx_ready"}, bus.tx_ready, 1'b1);
    check({tag, "_clk_rel"}, bus.ps2_clk_low, 1'b0);
    check({tag, "_data_rel"}, bus.ps2_data_low, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [9:0] frame;
    bit aborted;
    int dc;
    int cyc;

    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;

    // Reset state
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_clk_low", bus.ps2_clk_low, 1'b0);
    check("reset_data_low", bus.ps2_data_low, 1'b0);
    check("reset_busy", bus.busy, 1'b0);
    check("reset_done", bus.done, 1'b0);
    check("reset_status", bus.status, 2'b00);
    check("reset_tx_ready", bus.tx_ready, 1'b1);

    // 0xF4 acknowledged: bits 0,0,1,0,1,1,1,1 parity 0 stop 1
    start_tx(8'hF4);
    run_inhibit();
    dc = done_cnt;
    device(1'b1, 0, 0, frame, aborted);
    check("f4_frame", frame, 10'h2F4);
    check("f4_done_pulses", done_cnt - dc, 1);
    check_idle("f4", 2'b00);
    $display("txn send 0xF4 frame=%03h status=%0d", frame, bus.status);

    // 0xED not acknowledged: parity 1
    start_tx(8'hED);
    run_inhibit();
    dc = done_cnt;
    device(1'b0, 0, 0, frame, aborted);
    check("ed_frame", frame, 10'h3ED);
    check("ed_parity", frame[8], 1'b1);
    check("ed_done_pulses", done_cnt - dc, 1);
    check_idle("ed", 2'b01);
    $display("txn send 0xED frame=%03h status=%0d", frame, bus.status);

    // 0xFF with a silent device: timeout TMO cycles after START entry
    start_tx(8'hFF);
    run_inhibit();
    dc = done_cnt;
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < TMO + 500) begin
      @(negedge clk);
      cyc++;
    end
    check("tmo_latency", cyc, TMO);
    check_idle("tmo", 2'b10);
    bus.tx_data  = 8'h12;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    check("tmo_done_pulses", done_cnt - dc, 1);
    check("tmo_reaccept_busy", bus.busy, 1'b1);
    check("tmo_reaccept_clk_low", bus.ps2_clk_low, 1'b1);
    $display("txn send 0xFF timeout after %0d cycles status=2", cyc);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Stray request mid-frame is ignored
    start_tx(8'h5A);
    run_inhibit();
    dc = done_cnt;
    device(1'b1, 3, 0, frame, aborted);
    check("poke_frame", frame, 10'h35A);
    check("poke_done_pulses", done_cnt - dc, 1);
    check_idle("poke", 2'b00);
    $display("txn send 0x5A with stray request frame=%03h", frame);

    // Reset at bit 4: lines released, no done
    start_tx(8'h5A);
    run_inhibit();
    dc = done_cnt;
    device(1'b1, 0, 5, frame, aborted);
    check("rst_aborted", aborted, 1'b1);
    repeat (5) @(negedge clk);
    check("rst_no_done", done_cnt - dc, 0);
    $display("txn send 0x5A reset at bit 4");

    // Two-cycle glitch on the clock pin: no advance, watchdog keeps running
    start_tx(8'hFF);
    run_inhibit();
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < TMO + 500) begin
      if (cyc == 100) dev_clk_low = 1'b1;
      if (cyc == 102) dev_clk_low = 1'b0;
      if (cyc == 200) check("glitch_no_advance", bus.ps2_data_low, 1'b1);
      @(negedge clk);
      cyc++;
    end
    check("glitch_tmo_latency", cyc, TMO);
    check("glitch_status", bus.status, 2'b10);
    $display("txn send 0xFF with clock glitch timeout after %0d cycles", cyc);

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
